// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the instruction-fetch
//   requester (i_*) and the load/store requester (d_*). One memory transaction
//   is in flight at a time. When both requesters ask in the same free cycle, the
//   one that did not win the previous grant goes first.
//
// Parameters
//   ADDR_W  address width of both requesters and the memory port
//   DATA_W  data width
//   LAT     memory read latency in cycles (1..8); mem_rdata is valid exactly
//           LAT cycles after the issue cycle
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_req/i_addr               fetch read request, held until i_gnt
//   i_gnt/i_rvalid/i_rdata     fetch grant, read-data strobe and data
//   d_req/d_we/d_addr/d_wdata  load/store request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata     data grant, load-data strobe and data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory port
//   busy                       a read is in flight
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(LAT + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  // Requester encoding shared by owner and last_gnt.
  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             last_gnt_reg, last_gnt_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pick_d;
  logic             pick_i;

  // Read data is a plain pass-through; the rvalid strobes say who owns it.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // Reset masks busy in the cycle it is asserted so an abandoned read never
  // shows up on the outputs.
  assign busy = !reset && (state_reg == READ);

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    last_gnt_next = last_gnt_reg;
    cnt_next      = cnt_reg;
    i_gnt         = 1'b0;
    d_gnt         = 1'b0;
    i_rvalid      = 1'b0;
    d_rvalid      = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    // Data wins when alone, or in a conflict when fetch won last time.
    pick_d = d_req && (!i_req || (last_gnt_reg == FETCH));
    pick_i = i_req && !pick_d;

    // Reset outranks every request and any read that happens to be due.
    if (!reset) begin
      if (state_reg == IDLE) begin
        if (pick_d) begin
          d_gnt         = 1'b1;
          mem_en        = 1'b1;
          mem_we        = d_we;
          mem_addr      = d_addr;
          mem_wdata     = d_wdata;
          last_gnt_next = DATA;
          // A store finishes in its issue cycle; only loads occupy the port.
          if (!d_we) begin
            owner_next = DATA;
            cnt_next   = LAT_CNT;
            state_next = READ;
          end
        end else if (pick_i) begin
          i_gnt         = 1'b1;
          mem_en        = 1'b1;
          mem_addr      = i_addr;
          last_gnt_next = FETCH;
          owner_next    = FETCH;
          cnt_next      = LAT_CNT;
          state_next    = READ;
        end
      end else begin
        cnt_next = cnt_reg - CNT_ONE;
        // Counter reaches 1 exactly LAT cycles after the issue cycle.
        if (cnt_reg == CNT_ONE) begin
          state_next = IDLE;
          if (owner_reg == DATA) begin
            d_rvalid = 1'b1;
          end else begin
            i_rvalid = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= FETCH;
      last_gnt_reg <= FETCH;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      last_gnt_reg <= last_gnt_next;
      cnt_reg      <= cnt_next;
    end
  end

endmodule
